// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment demux router.
// Segment codes are active-low, so all-ones is a dark digit.
package seg7_pkg;

  localparam int unsigned SEG7_WIDTH = 7;
  localparam logic [SEG7_WIDTH-1:0] SEG7_BLANK = 7'b1111111;

  typedef enum logic {
    CH_EMPTY,
    CH_FULL
  } ch_state_e;

endpackage

// File: rtl/seg7_chan_buf.sv
// One-deep display channel buffer: holds one segment code behind a valid/ack handshake.
// The data register keeps the last code after ack so the digit stays lit.
module seg7_chan_buf
  import seg7_pkg::*;
#(
  parameter int unsigned     Width = SEG7_WIDTH,
  parameter logic [Width-1:0] Blank = SEG7_BLANK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic [Width-1:0] data_o,
  output logic             valid_o
);

  ch_state_e        state_q, state_d;
  logic [Width-1:0] data_q, data_d;
  logic             load;

  // Ready does not depend on this channel being selected; the top muxes it.
  assign ready_o = (state_q == CH_EMPTY) || ack_i;
  assign load    = valid_i && sel_i && ready_o;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      data_d = data_i;
    end
    unique case (state_q)
      CH_EMPTY: if (load) state_d = CH_FULL;
      CH_FULL:  if (ack_i && !load) state_d = CH_EMPTY;
      default:  state_d = CH_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_EMPTY;
      data_q  <= Blank;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == CH_FULL);

endmodule

// File: rtl/seg7_demux_router.sv
// Routes one segment-code stream to one of two buffered display channels.
// Only the select decode and the in_ready mux live here.
module seg7_demux_router
  import seg7_pkg::*;
#(
  parameter int unsigned      WIDTH = SEG7_WIDTH,
  parameter logic [WIDTH-1:0] BLANK = SEG7_BLANK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ack,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ack
);

  logic sel1, sel2;
  logic ready1, ready2;

  assign sel1 = ~in_select;
  assign sel2 = in_select;

  seg7_chan_buf #(
    .Width (WIDTH),
    .Blank (BLANK)
  ) u_chan1 (
    .clk     (clk),
    .rst     (rst),
    .sel_i   (sel1),
    .valid_i (in_valid),
    .data_i  (in_data),
    .ack_i   (out1_ack),
    .ready_o (ready1),
    .data_o  (out1_data),
    .valid_o (out1_valid)
  );

  seg7_chan_buf #(
    .Width (WIDTH),
    .Blank (BLANK)
  ) u_chan2 (
    .clk     (clk),
    .rst     (rst),
    .sel_i   (sel2),
    .valid_i (in_valid),
    .data_i  (in_data),
    .ack_i   (out2_ack),
    .ready_o (ready2),
    .data_o  (out2_data),
    .valid_o (out2_valid)
  );

  assign in_ready = in_select ? ready2 : ready1;

endmodule

// File: doc/seg7_demux_router.md
# seg7_demux_router

Routes a single 7-bit seven-segment code stream to one of two display channels: the demultiplexing counterpart of the 7-bit 2:1 selector used on the display path. Each channel holds one registered code with a valid/ack handshake toward its consumer (digit driver or scan logic). The upstream producer sees a valid/ready handshake and a channel select. The block sits between the game/score formatting logic and the per-digit display drivers.

## Interface
- `WIDTH`, 7: segment code width.
- `BLANK`, 7'b1111111: reset/idle code, active-low segments, all off.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  WIDTH  segment code from producer.
- `in_select`  input  1  destination: 0 = channel 1, 1 = channel 2.
- `in_valid`  input  1  producer offers `in_data`/`in_select`.
- `in_ready`  output  1  block accepts this cycle (combinational).
- `out1_data`, `out2_data`  output  WIDTH  held code per channel (registered).
- `out1_valid`, `out2_valid`  output  1  unconsumed code present (registered).
- `out1_ack`, `out2_ack`  input  1  consumer takes the current code.

## Operation
- Each channel is a one-deep buffer with states EMPTY and FULL.
- Transfer in: `in_valid & in_ready`. Data loads into the channel named by `in_select`. The other channel is untouched.
- `in_ready` = selected channel EMPTY, or FULL with its ack high this cycle.
- Channel transitions:
  - EMPTY + load -> FULL.
  - FULL + ack, no load -> EMPTY.
  - FULL + ack + load -> FULL with the new data.
  - FULL + load without ack cannot occur, because `in_ready` is low in that case.
- Ack while EMPTY is ignored. No state or data change.
- `outN_data` keeps the last loaded code after ack, so the display persists. Only `outN_valid` drops.
- The producer holds `in_data`/`in_select` stable while `in_valid & ~in_ready`. `in_ready` reflects the current `in_select` every cycle.
- Channels are independent. Acks on both channels in one cycle are legal.
- No width arithmetic. `in_data` passes bit-exact.

## Timing
- Reset (async assert): `out1_data` = `out2_data` = BLANK, `out1_valid` = `out2_valid` = 0, both channels EMPTY.
- Reset has no combinational path. `in_ready` follows channel state, so it is 1 during reset.
- Load latency: code accepted at edge N appears on `outN_data` with `outN_valid` = 1 after edge N.
- Ack at edge N: `outN_valid` = 0 after edge N, unless reloaded at the same edge.
- Throughput: one code per cycle to a channel whose consumer acks every cycle. Alternating channels also sustains one per cycle.
- Reset mid-operation: pending codes are discarded immediately, with no partial transfer. The first transfer after release happens at the first rising edge with `rst` low.

## Structure
- Package `seg7_pkg`:
  - `SEG7_WIDTH` = 7.
  - `SEG7_BLANK` = 7'b1111111.
  - Channel state enum {CH_EMPTY, CH_FULL}.
- Sub-module `seg7_chan_buf`: one channel (state, data register, valid, ready/load logic). It is instantiated twice.
- The top level holds only the select decode and the `in_ready` mux.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle. Required: both `outN_data` = 7'h7F, both valid = 0, `in_ready` = 1.
- Basic route: send 7'h40 with select = 0, then 7'h79 with select = 1, acks low. Required:
  - after edge 1, `out1_data` = 7'h40 and `out1_valid` = 1;
  - after edge 2, `out2_data` = 7'h79;
  - `in_ready` = 0 afterwards for either select.
- Backpressure: channel 1 FULL, `in_valid` held with 7'h24 and select = 0 for 3 cycles. Required: `in_ready` = 0 and `out1_data` unchanged. Ack on cycle 4 gives `in_ready` = 1 and `out1_data` = 7'h24 next cycle, valid stays 1.
- Simultaneous ack and load: channel 2 FULL (7'h30), ack2 with load 7'h19 in the same cycle. Required: `out2_data` = 7'h19, `out2_valid` = 1, no lost code.
- Spurious ack and persistence: ack1 while EMPTY has no effect. After a normal ack, `out1_valid` = 0 and `out1_data` keeps its last value.
- Reset mid-stream: channels FULL, assert `rst`. Required: BLANK/0 immediately. After release, a new load is accepted on the first edge.
